// File: rtl/filter_param_pkg.sv
// rtl/filter_param_pkg.sv - shared state encoding and fixed-point constants for filter_param_ctrl
package filter_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_RAMP = 2'd2
    } state_t;

    // F is unsigned with 1.0 at 2^17, Q1 is unsigned with 1.0 at 2^16
    localparam int F_ONE  = 1 << 17;
    localparam int Q1_ONE = 1 << 16;

    // 0.4, Q = 4 and the 0.8 stability ceiling for F
    localparam int F_RESET_DEFAULT  = (F_ONE * 2) / 5;
    localparam int Q1_RESET_DEFAULT = Q1_ONE / 4;
    localparam int F_MAX_DEFAULT    = (F_ONE * 4) / 5;

endpackage

// File: rtl/filter_tick_div.sv
// rtl/filter_tick_div.sv - loadable sample_tick down-counter producing the F step strobe
module filter_tick_div #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 en,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] load_val,
    output logic                 step
);

    logic [DIV_WIDTH-1:0] cnt;

    // Strobe on the tick that finds the counter exhausted; same tick reloads it
    assign step = tick && en && (cnt == '0);

    // Load on entry to the ramp, then count sample ticks down and wrap to the reload value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && en) begin
            if (cnt == '0) begin
                cnt <= load_val;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/filter_param_ctrl.sv
// rtl/filter_param_ctrl.sv - F/Q1 parameter sequencer for filter_svf (optional FILTER_PARAM_CTRL_EXP_EN exponential glide)
module filter_param_ctrl
    import filter_param_pkg::*;
#(
    parameter int F_WIDTH   = 18,
    parameter int Q1_WIDTH  = 18,
    parameter int DIV_WIDTH = 8,
    parameter int F_RESET   = F_RESET_DEFAULT,
    parameter int Q1_RESET  = Q1_RESET_DEFAULT,
    parameter int F_MAX     = F_MAX_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [F_WIDTH-1:0]   cfg_f_target,
    input  logic [Q1_WIDTH-1:0]  cfg_q1,
    input  logic [F_WIDTH-1:0]   cfg_step,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    output logic [F_WIDTH-1:0]   F,
    output logic [Q1_WIDTH-1:0]  Q1,
    output logic                 busy,
    output logic                 done
);

    localparam logic [F_WIDTH-1:0]  F_RST_V  = F_WIDTH'(F_RESET);
    localparam logic [Q1_WIDTH-1:0] Q1_RST_V = Q1_WIDTH'(Q1_RESET);
    localparam logic [F_WIDTH-1:0]  F_MAX_V  = F_WIDTH'(F_MAX);
    localparam logic [F_WIDTH:0]    F_MAX_W  = {1'b0, F_MAX_V};

    state_t               state, state_next;
    logic [F_WIDTH-1:0]   tgt_q;
    logic [Q1_WIDTH-1:0]  q1_q;
    logic [F_WIDTH-1:0]   step_q;
    logic [DIV_WIDTH-1:0] div_q;

    logic                 accept;
    logic                 step_strobe;
    logic [F_WIDTH-1:0]   diff;
    logic [F_WIDTH-1:0]   step_eff;
    logic                 jump;
    logic [F_WIDTH:0]     f_wide;
    logic [F_WIDTH-1:0]   f_next;
    logic                 reached;

    assign cfg_ready = rst_n && (state == ST_IDLE);
    assign accept    = cfg_valid && cfg_ready;
    assign busy      = (state != ST_IDLE);

    filter_tick_div #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (sample_tick),
        .en       (state == ST_RAMP),
        .load     ((state == ST_PEND) && sample_tick),
        .load_val (div_q),
        .step     (step_strobe)
    );

    // Next F value for one step: land on target when within one step, else move toward it and clamp
    always_comb begin
        diff     = (tgt_q >= F) ? (tgt_q - F) : (F - tgt_q);
`ifdef FILTER_PARAM_CTRL_EXP_EN
        step_eff = diff >> step_q[3:0];
        if (step_eff == '0) begin
            step_eff = F_WIDTH'(1);
        end
        jump     = (step_q[3:0] == 4'd0) || (diff <= step_eff);
`else
        step_eff = step_q;
        jump     = (step_q == '0) || (diff <= step_eff);
`endif
        if (jump) begin
            f_wide = {1'b0, tgt_q};
        end else if (tgt_q > F) begin
            f_wide = {1'b0, F} + {1'b0, step_eff};
            if (f_wide > F_MAX_W) begin
                f_wide = F_MAX_W;
            end
        end else begin
            f_wide = {1'b0, F} - {1'b0, step_eff};
            if (f_wide[F_WIDTH]) begin
                f_wide = '0;
            end
        end
        f_next  = f_wide[F_WIDTH-1:0];
        reached = (f_next == tgt_q);
    end

    // Sequencing: accept in IDLE, wait a fresh tick in PEND, glide in RAMP until target is hit
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_PEND;
            ST_PEND: if (sample_tick) state_next = ST_RAMP;
            ST_RAMP: if (step_strobe && reached) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the accepted request; target is pre-clamped so F can never be asked to pass F_MAX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_q  <= '0;
            q1_q   <= '0;
            step_q <= '0;
            div_q  <= '0;
        end else if (accept) begin
            tgt_q  <= (cfg_f_target > F_MAX_V) ? F_MAX_V : cfg_f_target;
            q1_q   <= cfg_q1;
            step_q <= cfg_step;
            div_q  <= cfg_div;
        end
    end

    // Filter-facing registers: Q1 on the ramp-start tick, F on step strobes, done with the final step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            F    <= F_RST_V;
            Q1   <= Q1_RST_V;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((state == ST_PEND) && sample_tick) begin
                Q1 <= q1_q;
            end
            if ((state == ST_RAMP) && step_strobe) begin
                F <= f_next;
                if (reached) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_filter_param_ctrl.sv
// tb/tb_filter_param_ctrl.sv - directed self-checking bench for filter_param_ctrl
`timescale 1ns/1ps
module tb_filter_param_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [17:0] cfg_f_target = '0;
    logic [17:0] cfg_q1 = '0;
    logic [17:0] cfg_step = '0;
    logic [7:0]  cfg_div = '0;
    logic [17:0] F;
    logic [17:0] Q1;
    logic        busy;
    logic        done;

    int n_cmp  = 0;
    int n_fail = 0;

    filter_param_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_tick  (sample_tick),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_f_target (cfg_f_target),
        .cfg_q1       (cfg_q1),
        .cfg_step     (cfg_step),
        .cfg_div      (cfg_div),
        .F            (F),
        .Q1           (Q1),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
    endtask

    // One sample period of about 128 clocks ending in a tick; returns 1 ns after the tick edge
    task automatic gap_tick();
        repeat (126) @(posedge clk);
        pulse_tick();
    endtask

    task automatic send_cfg(input logic [17:0] tgt, input logic [17:0] q1, input logic [17:0] stp,
                            input logic [7:0] dv, input logic hold, input logic tick_too);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        cfg_f_target = tgt;
        cfg_q1       = q1;
        cfg_step     = stp;
        cfg_div      = dv;
        cfg_valid    = 1'b1;
        sample_tick  = tick_too;
        for (int i = 0; i < 2000; i++) begin
            if (cfg_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
        end
        #1;
        sample_tick = 1'b0;
        if (!hold) cfg_valid = 1'b0;
        chk("handshake", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] exp_f;

        // reset state
        repeat (5) @(posedge clk);
        #1;
        chk("rst_ready_low", 32'(cfg_ready), 32'd0);
        chk("rst_f", 32'(F), 32'd52428);
        chk("rst_q1", 32'(Q1), 32'd16384);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(cfg_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

`ifdef FILTER_PARAM_CTRL_EXP_EN
        // jump to 0, then exponential glide to 65536 with shift 2
        send_cfg(18'd0, 18'd16384, 18'd0, 8'd0, 1'b0, 1'b0);
        gap_tick();
        gap_tick();
        chk("exp_zero", 32'(F), 32'd0);
        chk("exp_zero_done", 32'(done), 32'd1);
        send_cfg(18'd65536, 18'd16384, 18'd2, 8'd0, 1'b0, 1'b0);
        gap_tick();
        gap_tick();
        chk("exp_s1", 32'(F), 32'd16384);
        gap_tick();
        chk("exp_s2", 32'(F), 32'd28672);
        gap_tick();
        chk("exp_s3", 32'(F), 32'd37888);
        for (int k = 0; k < 100 && busy; k++) gap_tick();
        chk("exp_final", 32'(F), 32'd65536);
        chk("exp_done", 32'(done), 32'd1);
        chk("exp_idle", 32'(busy), 32'd0);
`else
        // linear ramp 52428 -> 60000, step 1000, div 0
        send_cfg(18'd60000, 18'd32768, 18'd1000, 8'd0, 1'b0, 1'b0);
        chk("lin_busy", 32'(busy), 32'd1);
        chk("lin_ready", 32'(cfg_ready), 32'd0);
        gap_tick();
        chk("lin_q1", 32'(Q1), 32'd32768);
        chk("lin_f_start", 32'(F), 32'd52428);
        exp_f = 32'd52428;
        for (int k = 1; k <= 8; k++) begin
            repeat (60) @(posedge clk);
            #1;
            chk("lin_hold", 32'(F), exp_f);
            repeat (66) @(posedge clk);
            pulse_tick();
            exp_f = (k < 8) ? 32'(52428 + 1000 * k) : 32'd60000;
            chk("lin_f", 32'(F), exp_f);
            chk("lin_done", 32'(done), (k == 8) ? 32'd1 : 32'd0);
            chk("lin_busy_k", 32'(busy), (k < 8) ? 32'd1 : 32'd0);
        end
        @(posedge clk);
        #1;
        chk("lin_done_pulse", 32'(done), 32'd0);
        chk("lin_ready_back", 32'(cfg_ready), 32'd1);

        // divider: restart from reset value, coincident tick at handshake is ignored
        do_reset();
        send_cfg(18'd52728, 18'd20000, 18'd100, 8'd3, 1'b0, 1'b1);
        chk("div_q1_unchanged", 32'(Q1), 32'd16384);
        chk("div_pend_busy", 32'(busy), 32'd1);
        gap_tick();
        chk("div_q1", 32'(Q1), 32'd20000);
        chk("div_f_start", 32'(F), 32'd52428);
        for (int t = 1; t <= 12; t++) begin
            gap_tick();
            chk("div_f", 32'(F), 32'(52428 + 100 * (t / 4)));
            chk("div_done", 32'(done), (t == 12) ? 32'd1 : 32'd0);
        end

        // clamp and jump
        send_cfg(18'd131071, 18'd16384, 18'd0, 8'd0, 1'b0, 1'b0);
        gap_tick();
        chk("clamp_pend", 32'(F), 32'd52728);
        gap_tick();
        chk("clamp_f", 32'(F), 32'd104857);
        chk("clamp_done", 32'(done), 32'd1);
        chk("clamp_idle", 32'(busy), 32'd0);

        // backpressure: valid held through the ramp carrying a second request
        send_cfg(18'd100000, 18'd20000, 18'd1000, 8'd0, 1'b1, 1'b0);
        cfg_f_target = 18'd90000;
        cfg_q1       = 18'd30000;
        cfg_step     = 18'd500;
        cfg_div      = 8'd0;
        gap_tick();
        chk("bp_ready_pend", 32'(cfg_ready), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            gap_tick();
            exp_f = (k < 5) ? 32'(104857 - 1000 * k) : 32'd100000;
            chk("bp_f", 32'(F), exp_f);
            if (k < 5) chk("bp_ready", 32'(cfg_ready), 32'd0);
        end
        chk("bp_done", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        chk("bp_second_accepted", 32'(busy), 32'd1);
        chk("bp_second_ready", 32'(cfg_ready), 32'd0);
        gap_tick();
        chk("bp_q1", 32'(Q1), 32'd30000);
        gap_tick();
        gap_tick();
        chk("bp_f2", 32'(F), 32'd99000);

        // asynchronous reset mid-ramp
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_f", 32'(F), 32'd52428);
        chk("arst_q1", 32'(Q1), 32'd16384);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        gap_tick();
        gap_tick();
        chk("arst_lost_f", 32'(F), 32'd52428);
        chk("arst_lost_busy", 32'(busy), 32'd0);
        chk("arst_lost_q1", 32'(Q1), 32'd16384);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
